// File: rtl/ov_addsub_acc.sv
// ov_addsub_acc
//   Registered signed add/subtract unit with two's-complement overflow
//   detection, optional saturation, accumulate mode and sticky/counted
//   overflow status.
//
// Parameters
//   WIDTH     operand/result width (signed), 2..32
//   SATURATE  0: wrap on overflow, 1: clamp to max/min
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    accept one operation this cycle (no backpressure)
//   s           0: X + b, 1: X - b
//   acc_mode    0: X = a, 1: X = y (accumulate)
//   a, b        signed operands
//   clr_sticky  synchronous clear of v_sticky and ov_count
//   out_valid   one-cycle pulse per accepted operation
//   y           registered result / accumulator
//   v           overflow flag of the result on y
//   v_sticky    set by any overflow since reset/clear
//   ov_count    overflow count since reset/clear, saturates at 255
module ov_addsub_acc #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             s,
  input  logic             acc_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_sticky,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             v,
  output logic             v_sticky,
  output logic [7:0]       ov_count
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] x_op;
  logic [WIDTH:0]   x_ext;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] res;
  logic             ov_hit;

  // The sum is formed one bit wider than the operands so that X - b is
  // exact even for b = most negative value (no separate negation of b).
  always_comb begin
    x_op  = acc_mode ? y : a;
    x_ext = {x_op[WIDTH-1], x_op};
    b_ext = {b[WIDTH-1], b};
    sum   = s ? (x_ext - b_ext) : (x_ext + b_ext);
    // Out of range exactly when the extended sign disagrees with the
    // result sign bit; sum[WIDTH] then gives the true sign.
    ovf   = sum[WIDTH] ^ sum[WIDTH-1];
    res   = sum[WIDTH-1:0];
    if (SATURATE && ovf) begin
      res = sum[WIDTH] ? MAX_NEG : MAX_POS;
    end
    ov_hit = in_valid & ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      v         <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y <= res;
        v <= ovf;
      end
    end
  end

  // A new overflow wins over a clear issued in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_sticky <= 1'b0;
      ov_count <= '0;
    end else begin
      if (ov_hit) begin
        v_sticky <= 1'b1;
      end else if (clr_sticky) begin
        v_sticky <= 1'b0;
      end

      if (clr_sticky) begin
        ov_count <= {7'd0, ov_hit};
      end else if (ov_hit && (ov_count != 8'hFF)) begin
        ov_count <= ov_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ov_addsub_acc.sv
module tb_ov_addsub_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       s = 1'b0;
  logic       acc_mode = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       clr_sticky = 1'b0;

  logic       ov0, v0, st0, ov1, v1, st1;
  logic [7:0] y0, c0, y1, c1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] y0; logic v0; logic st0; logic [7:0] c0;
    logic [7:0] y1; logic v1; logic st1; logic [7:0] c1;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Wrap instance
  ov_addsub_acc #(.WIDTH(8), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s(s), .acc_mode(acc_mode),
    .a(a), .b(b), .clr_sticky(clr_sticky),
    .out_valid(ov0), .y(y0), .v(v0), .v_sticky(st0), .ov_count(c0));

  // Saturating instance
  ov_addsub_acc #(.WIDTH(8), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s(s), .acc_mode(acc_mode),
    .a(a), .b(b), .clr_sticky(clr_sticky),
    .out_valid(ov1), .y(y1), .v(v1), .v_sticky(st1), .ov_count(c1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected entry per out_valid pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid_agree", {31'd0, ov1}, {31'd0, ov0});
      if (ov0) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wrap_y", {24'd0, y0}, {24'd0, e.y0});
          chk("wrap_v", {31'd0, v0}, {31'd0, e.v0});
          chk("wrap_sticky", {31'd0, st0}, {31'd0, e.st0});
          chk("wrap_count", {24'd0, c0}, {24'd0, e.c0});
          chk("sat_y", {24'd0, y1}, {24'd0, e.y1});
          chk("sat_v", {31'd0, v1}, {31'd0, e.v1});
          chk("sat_sticky", {31'd0, st1}, {31'd0, e.st1});
          chk("sat_count", {24'd0, c1}, {24'd0, e.c1});
        end
      end
    end
  end

  // Called at posedge+1; returns at the next posedge+1.
  task automatic op(input logic ts, input logic tacc, input int ta, input int tb,
                    input logic tclr,
                    input int ey0, input logic ev0, input logic est0, input int ec0,
                    input int ey1, input logic ev1, input logic est1, input int ec1);
    exp_t e;
    in_valid = 1'b1; s = ts; acc_mode = tacc; a = ta[7:0]; b = tb[7:0]; clr_sticky = tclr;
    e.y0 = ey0[7:0]; e.v0 = ev0; e.st0 = est0; e.c0 = ec0[7:0];
    e.y1 = ey1[7:0]; e.v1 = ev1; e.st1 = est1; e.c1 = ec1[7:0];
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; clr_sticky = 1'b0;
  endtask

  // One cycle with no operation; checks hold behaviour and status.
  task automatic idle(input logic tclr, input int ey0, input int ey1,
                      input logic est, input int ec0, input int ec1);
    in_valid = 1'b0; clr_sticky = tclr;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    chk("idle_out_valid", {30'd0, ov0, ov1}, 32'd0);
    chk("idle_wrap_y", {24'd0, y0}, ey0);
    chk("idle_sat_y", {24'd0, y1}, ey1);
    chk("idle_sticky", {30'd0, st0, st1}, {30'd0, est, est});
    chk("idle_count", {16'd0, c0, c1}, {16'd0, ec0[7:0], ec1[7:0]});
  endtask

  task automatic check_zero(input string name);
    chk(name, {ov0, v0, st0, ov1, v1, st1, y0, y1, c0, c1}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; clr_sticky = 1'b0;
    #1 check_zero("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int e0, e1;
    do_reset();

    // Basic add/sub and boundary cases
    op(0, 0, 100, 50, 0,   8'h96, 1, 1, 1,   127,   1, 1, 1);
    op(1, 0, 5, 3, 0,      2,     0, 1, 1,   2,     0, 1, 1);
    op(1, 0, -128, 1, 0,   127,   1, 1, 2,   8'h80, 1, 1, 2);
    op(1, 0, 0, -128, 0,   8'h80, 1, 1, 3,   127,   1, 1, 3);
    op(0, 0, 127, -128, 0, 8'hFF, 0, 1, 3,   8'hFF, 0, 1, 3);
    op(1, 0, -1, -128, 0,  127,   0, 1, 3,   127,   0, 1, 3);
    idle(0, 127, 127, 1, 3, 3);
    idle(1, 127, 127, 0, 0, 0);

    // Accumulate from reset; a is ignored in accumulate mode
    do_reset();
    op(0, 1, 55, 64, 0,    64,    0, 0, 0,   64,  0, 0, 0);
    op(0, 1, 55, 64, 0,    8'h80, 1, 1, 1,   127, 1, 1, 1);
    op(0, 1, 55, 64, 0,    8'hC0, 0, 1, 1,   127, 1, 1, 2);
    idle(0, 8'hC0, 127, 1, 1, 2);

    // Clear together with an overflow: sticky stays, count loads 1
    op(0, 0, 100, 100, 1,  8'hC8, 1, 1, 1,   127, 1, 1, 1);
    // Accumulating subtract of the most negative value
    op(1, 1, 0, -128, 0,   72,    0, 1, 1,   127, 1, 1, 2);

    // Counter saturation over 256 overflowing adds
    e0 = 1; e1 = 2;
    for (int i = 0; i < 256; i++) begin
      e0 = (e0 < 255) ? e0 + 1 : 255;
      e1 = (e1 < 255) ? e1 + 1 : 255;
      op(0, 0, 100, 100, 0, 8'hC8, 1, 1, e0, 127, 1, 1, e1);
    end
    op(1, 0, -100, 100, 0, 56, 1, 1, 255,    8'h80, 1, 1, 255);
    idle(1, 56, 8'h80, 0, 0, 0);

    // Asynchronous reset mid-cycle with an op in flight
    op(0, 0, 100, 50, 0,   8'h96, 1, 1, 1,   127, 1, 1, 1);
    @(negedge clk); #1;
    in_valid = 1'b1; s = 1'b0; acc_mode = 1'b0; a = 8'd100; b = 8'd100;
    #1 rst_n = 1'b0;
    #1 check_zero("async_reset_immediate");
    @(posedge clk); #1;
    check_zero("async_reset_held");
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle(0, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0, 0, 0);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ov_addsub_acc.md
# ov_addsub_acc

Parametrised, registered signed add/subtract unit with two's-complement overflow detection, optional saturation, an accumulate mode, and sticky/counted overflow status. It extends the team's single-bit combinational overflow detector to a WIDTH-bit clocked datapath. It sits between operand sources, such as the switch/register front end, and result consumers that need a per-result and a latched overflow indication.

## Interface
- WIDTH, 8: operand/result width in bits, signed two's complement; legal range 2..32.
- SATURATE, 0: 0 = wrap on overflow; 1 = clamp to the most positive/most negative value.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low, synchronous release by the driver.
- in_valid  in  1  operands/op valid this cycle; one operation accepted per cycle, no backpressure.
- s  in  1  operation select: 0 = add, 1 = subtract (X − b).
- acc_mode  in  1  0 = X is a; 1 = X is current y (accumulate).
- a  in  WIDTH  signed operand A.
- b  in  WIDTH  signed operand B.
- clr_sticky  in  1  synchronous clear of v_sticky and ov_count.
- out_valid  out  1  y/v valid, one-cycle pulse per accepted op.
- y  out  WIDTH  registered result; also the accumulator.
- v  out  1  overflow of the result currently on y.
- v_sticky  out  1  set by any overflow since reset/clear.
- ov_count  out  8  number of overflows since reset/clear, saturating at 255.

## Operation
- Reset (rst_n=0, asynchronous): y=0, v=0, out_valid=0, v_sticky=0, ov_count=0. Reset asserted mid-stream drops any in-flight result; no out_valid follows.
- When in_valid=1, X = acc_mode ? y : a, and Y = s ? −b : b. The sum is computed at WIDTH+1 bits (sign-extended) as X + Y. For subtract, the sum is X − b directly, not X + (−b) at WIDTH bits, so b = min is handled correctly.
- Overflow: the WIDTH+1-bit sum is outside [−2^(WIDTH−1), 2^(WIDTH−1)−1]. Equivalent rule: bit WIDTH ≠ bit WIDTH−1 of the extended sum.
- Result:
  - No overflow: low WIDTH bits.
  - Overflow, SATURATE=0: low WIDTH bits (wrap).
  - Overflow, SATURATE=1: positive overflow → 2^(WIDTH−1)−1; negative overflow → −2^(WIDTH−1).
- The registered result is written to y; v is registered with it. In accumulate mode the saturated or wrapped value is what feeds back.
- When in_valid=0: y and v hold, and out_valid=0.
- v_sticky: set on any cycle where an accepted op overflows. Cleared by clr_sticky only when no overflow is registered that same cycle. Simultaneous overflow and clr_sticky leaves v_sticky=1.
- ov_count: increments by 1 per overflowing op, holds at 255. Simultaneous clr_sticky and overflow loads 1; clr_sticky alone loads 0.
- acc_mode=1 with y freshly reset uses 0 as X.

## Timing
- Latency is one clock: inputs sampled at edge n appear on y/v/out_valid after edge n, and out_valid is high for exactly one cycle.
- Throughput is one op per cycle. Back-to-back accumulate ops use the y registered at the previous edge.
- v_sticky and ov_count update on the same edge as the y/v they report.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, SATURATE=0:
  - add 100 + 50 → next cycle y=0x96 (−106), v=1, out_valid=1 for one cycle, v_sticky=1, ov_count=1.
  - add 5 − 3 (s=1) → y=2, v=0.
  - sub −128 − 1 → y=127, v=1.
  - sub 0 − (−128) → y=−128, v=1.
- WIDTH=8, SATURATE=1: 100 + 50 → y=127, v=1. Then −128 − 1 → y=−128, v=1, ov_count=2.
- Accumulate, WIDTH=8, SATURATE=0: from reset, acc_mode=1, b=64, three consecutive adds → y=64 (v=0), then −128 (v=1), then −64 (v=0); v_sticky stays 1 and ov_count=1. With SATURATE=1 the same sequence gives 64, 127 (v=1), 127 (v=1), ov_count=2.
- Sticky/counter:
  - 256 consecutive overflowing adds → ov_count holds at 255.
  - clr_sticky alone → v_sticky=0, ov_count=0.
  - clr_sticky in the same cycle as an overflowing op → v_sticky=1, ov_count=1.
- Reset: assert rst_n=0 asynchronously mid-cycle with in_valid=1. y, v, out_valid, v_sticky and ov_count go to 0 immediately, with no out_valid after release. Idle cycles (in_valid=0) hold y unchanged with out_valid=0.
